// File: rtl/ahb_pkg.sv
// ahb_pkg
// Shared AHB-Lite encodings for the Wishbone-to-AHB master bridge:
// HTRANS/HSIZE/HBURST/HPROT codes, the bridge FSM state encoding and the
// result record produced by the SEL_I decoder.
package ahb_pkg;

    // HTRANS codes
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // HSIZE codes
    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DATA    = 4'b0001;

    // Bridge FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_TERM = 2'd3;

    // Byte-lane decode result: legality, transfer size and HADDR[1:0]
    typedef struct packed {
        logic       legal;
        logic [2:0] size;
        logic [1:0] offset;
    } sel_decode_t;

endpackage

// File: rtl/wb_ahb_master_bridge_if.sv
// wb_ahb_master_bridge_if
// Bus bundle for the bridge: the Wishbone B3 slave-side signals coming from
// the MAC DMA plus the AHB-Lite master signals going to the system bus.
//   modport master : the bridge's view (AHB master / Wishbone slave)
//   modport slave  : the environment's view (Wishbone master + AHB slave)
interface wb_ahb_master_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Wishbone side
    logic [ADDR_WIDTH-1:0] ADR_I;
    logic [DATA_WIDTH-1:0] DAT_I;
    logic [3:0]            SEL_I;
    logic [2:0]            CTI_I;
    logic [1:0]            BTE_I;
    logic                  CYC_I;
    logic                  STB_I;
    logic                  WE_I;
    logic [DATA_WIDTH-1:0] DAT_O;
    logic                  ACK_O;
    logic                  ERR_O;
    logic                  RTY_O;

    // AHB-Lite side
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic                  HMASTLOCK;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HREADY;
    logic                  HRESP;

    modport master (
        input  ADR_I, DAT_I, SEL_I, CTI_I, BTE_I, CYC_I, STB_I, WE_I,
        output DAT_O, ACK_O, ERR_O, RTY_O,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        output ADR_I, DAT_I, SEL_I, CTI_I, BTE_I, CYC_I, STB_I, WE_I,
        input  DAT_O, ACK_O, ERR_O, RTY_O,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        output HRDATA, HREADY, HRESP
    );

endinterface

// File: rtl/wb_sel_decode.sv
// wb_sel_decode
// Purely combinational map from a Wishbone byte-lane select to an AHB
// transfer: only naturally aligned byte, halfword and word patterns are legal.
//   i_sel : Wishbone SEL_I
//   o_dec : {legal, HSIZE, HADDR[1:0]}
module wb_sel_decode
    import ahb_pkg::*;
(
    input  logic [3:0]  i_sel,
    output sel_decode_t o_dec
);

    always_comb begin
        o_dec = '{legal: 1'b0, size: HSIZE_WORD, offset: 2'b00};
        unique case (i_sel)
            4'b1111: o_dec = '{legal: 1'b1, size: HSIZE_WORD, offset: 2'b00};
            4'b0011: o_dec = '{legal: 1'b1, size: HSIZE_HALF, offset: 2'b00};
            4'b1100: o_dec = '{legal: 1'b1, size: HSIZE_HALF, offset: 2'b10};
            4'b0001: o_dec = '{legal: 1'b1, size: HSIZE_BYTE, offset: 2'b00};
            4'b0010: o_dec = '{legal: 1'b1, size: HSIZE_BYTE, offset: 2'b01};
            4'b0100: o_dec = '{legal: 1'b1, size: HSIZE_BYTE, offset: 2'b10};
            4'b1000: o_dec = '{legal: 1'b1, size: HSIZE_BYTE, offset: 2'b11};
            default: ;
        endcase
    end

endmodule

// File: rtl/wb_ahb_master_bridge.sv
// wb_ahb_master_bridge
// Turns each Wishbone B3 beat from the ethmac DMA into one non-pipelined AHB
// SINGLE transfer. Illegal byte-lane selects and AHB ERROR responses are
// returned as ERR_O; RTY_O is never used.
//   HCLK, HRESETn : bridge clock, asynchronous active-low reset
//   bus           : wb_ahb_master_bridge_if.master (Wishbone + AHB-Lite)
module wb_ahb_master_bridge
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    wb_ahb_master_bridge_if.master bus
);

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_haddr;
    logic [2:0]            r_hsize;
    logic                  r_hwrite;
    logic [DATA_WIDTH-1:0] r_hwdata;
    logic [DATA_WIDTH-1:0] r_dato;
    logic                  r_ack;
    logic                  r_err;

    sel_decode_t           w_dec;
    logic                  w_req;
    logic                  w_unused;

    wb_sel_decode u_sel_decode (
        .i_sel (bus.SEL_I),
        .o_dec (w_dec)
    );

    assign w_req    = bus.CYC_I & bus.STB_I;
    assign w_unused = ^{bus.CTI_I, bus.BTE_I, bus.ADR_I[1:0]};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state  <= ST_IDLE;
            r_haddr  <= '0;
            r_hsize  <= HSIZE_WORD;
            r_hwrite <= 1'b0;
            r_hwdata <= '0;
            r_dato   <= '0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        if (w_dec.legal) begin
                            r_haddr  <= {bus.ADR_I[ADDR_WIDTH-1:2], w_dec.offset};
                            r_hsize  <= w_dec.size;
                            r_hwrite <= bus.WE_I;
                            r_hwdata <= bus.DAT_I;
                            r_state  <= ST_ADDR;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= ST_TERM;
                        end
                    end
                end
                ST_ADDR: begin
                    if (bus.HREADY) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // HTRANS is already IDLE here, so the second cycle of a
                    // two-cycle ERROR response needs no special handling.
                    if (bus.HREADY) begin
                        r_state <= ST_TERM;
                        if (bus.HRESP) begin
                            r_err <= 1'b1;
                        end else begin
                            r_ack <= 1'b1;
                            if (!r_hwrite) begin
                                r_dato <= bus.HRDATA;
                            end
                        end
                    end
                end
                ST_TERM: begin
                    // Never re-sample STB_I here: it is still high from the
                    // beat being acknowledged.
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Termination is registered; a master that has dropped CYC_I by the
    // termination cycle gets nothing.
    assign bus.ACK_O     = r_ack & bus.CYC_I;
    assign bus.ERR_O     = r_err & bus.CYC_I;
    assign bus.RTY_O     = 1'b0;
    assign bus.DAT_O     = r_dato;

    assign bus.HTRANS    = (r_state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.HADDR     = r_haddr;
    assign bus.HWRITE    = r_hwrite;
    assign bus.HSIZE     = r_hsize;
    assign bus.HWDATA    = r_hwdata;
    assign bus.HBURST    = HBURST_SINGLE;
    assign bus.HPROT     = HPROT_DATA;
    assign bus.HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_wb_ahb_master_bridge.sv
// tb_wb_ahb_master_bridge
// Drives Wishbone beats into the bridge while acting as an AHB-Lite slave
// with programmable address-phase waits, data-phase waits and ERROR replies.
module tb_wb_ahb_master_bridge;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    wb_ahb_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    wb_ahb_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] ref_dato;

    typedef struct {
        logic [31:0] adr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] dat;
        int          aw;
        int          ws;
        logic        er;
        logic [31:0] rdata;
        int          exp_cyc;
        logic        exp_err;
        logic        exp_legal;
        logic [31:0] exp_haddr;
        logic [2:0]  exp_hsize;
        logic [31:0] exp_dato;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One Wishbone beat plus AHB slave behaviour. Cycle 0 is the cycle in
    // which the bridge sees the request; term_cyc is the cycle of ACK/ERR.
    task automatic run_beat(
        input  logic [31:0] adr, input logic [3:0] sel, input logic we,
        input  logic [31:0] dat, input int aw, input int ws, input logic er,
        input  logic [31:0] rdata, input logic [2:0] cti, input logic drop_cyc,
        input  int max_cyc,
        output int term_cyc, output logic t_ack, output logic t_err,
        output int n_ns, output logic [31:0] haddr, output logic [2:0] hsize,
        output logic hwrite, output int bad);
        int di;
        int awl;
        int dc;
        @(posedge HCLK); #1;
        bus.ADR_I = adr; bus.SEL_I = sel; bus.WE_I = we; bus.DAT_I = dat;
        bus.CTI_I = cti; bus.CYC_I = 1'b1; bus.STB_I = 1'b1;
        bus.HREADY = 1'b1; bus.HRESP = 1'b0;
        term_cyc = -1; t_ack = 1'b0; t_err = 1'b0; n_ns = 0;
        haddr = '0; hsize = '0; hwrite = 1'b0; bad = 0;
        di = -1; awl = aw; dc = ws + (er ? 2 : 1);
        for (int k = 0; k < max_cyc; k++) begin
            if (k > 0) begin
                @(posedge HCLK); #1;
                if (di >= 0) begin
                    if (di == 0 && drop_cyc) begin
                        bus.CYC_I = 1'b0; bus.STB_I = 1'b0;
                    end
                    bus.HREADY = (di == dc - 1);
                    bus.HRESP  = er && (di >= dc - 2);
                    bus.HRDATA = (di == dc - 1) ? rdata : $urandom;
                end else if (bus.HTRANS == T_NONSEQ && awl > 0) begin
                    bus.HREADY = 1'b0; bus.HRESP = 1'b0; awl--;
                end else begin
                    bus.HREADY = 1'b1; bus.HRESP = 1'b0;
                end
            end
            @(negedge HCLK);
            if (di >= 0) begin
                if (bus.HTRANS != T_IDLE) bad++;
                if (we && bus.HWDATA != dat) bad++;
                if (bus.HREADY) di = -1; else di++;
            end else if (bus.HTRANS == T_NONSEQ && bus.HREADY) begin
                n_ns++; haddr = bus.HADDR; hsize = bus.HSIZE; hwrite = bus.HWRITE;
                di = 0;
            end
            if ((bus.ACK_O || bus.ERR_O) && term_cyc < 0) begin
                term_cyc = k; t_ack = bus.ACK_O; t_err = bus.ERR_O;
                break;
            end
        end
    endtask

    task automatic release_bus();
        @(posedge HCLK); #1;
        bus.CYC_I = 1'b0; bus.STB_I = 1'b0; bus.CTI_I = 3'b000;
        bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    endtask

    task automatic check_beat(
        input string tag, input int exp_cyc, input logic exp_err, input logic exp_legal,
        input logic [31:0] exp_haddr, input logic [2:0] exp_hsize, input logic exp_we,
        input logic [31:0] exp_dato,
        input int term_cyc, input logic t_ack, input logic t_err, input int n_ns,
        input logic [31:0] haddr, input logic [2:0] hsize, input logic hwrite, input int bad);
        check({tag, ".term_cyc"}, term_cyc, exp_cyc);
        check({tag, ".ack"}, {31'd0, t_ack}, {31'd0, !exp_err});
        check({tag, ".err"}, {31'd0, t_err}, {31'd0, exp_err});
        check({tag, ".n_nonseq"}, n_ns, exp_legal ? 1 : 0);
        if (exp_legal) begin
            check({tag, ".haddr"}, haddr, exp_haddr);
            check({tag, ".hsize"}, {29'd0, hsize}, {29'd0, exp_hsize});
            check({tag, ".hwrite"}, {31'd0, hwrite}, {31'd0, exp_we});
            check({tag, ".data_phase"}, bad, 0);
        end
        check({tag, ".dat_o"}, bus.DAT_O, exp_dato);
    endtask

    // Reference: legal selects are one lane, an even-aligned lane pair, or
    // all four lanes; expectations follow from that and the phase counts.
    task automatic model_beat(
        input string tag, input logic [31:0] adr, input logic [3:0] sel, input logic we,
        input logic [31:0] dat, input int aw, input int ws, input logic er,
        input logic [31:0] rdata);
        int ones;
        int low;
        logic legal;
        logic [2:0] size;
        logic [31:0] ea;
        int ecyc;
        int term_cyc; logic t_ack; logic t_err; int n_ns;
        logic [31:0] haddr; logic [2:0] hsize; logic hwrite; int bad;
        ones = 0; low = -1;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                ones++;
                if (low < 0) low = b;
            end
        end
        legal = (ones == 4) || (ones == 1) || (ones == 2 && (low % 2) == 0 && sel[low + 1]);
        size  = (ones == 4) ? 3'd2 : (ones == 2) ? 3'd1 : 3'd0;
        ea    = {adr[31:2], (ones == 4) ? 2'b00 : 2'(low)};
        ecyc  = legal ? 2 + aw + ws + (er ? 2 : 1) : 1;
        if (legal && !we && !er) ref_dato = rdata;
        run_beat(adr, sel, we, dat, aw, ws, er, rdata, 3'b000, 1'b0, 30,
                 term_cyc, t_ack, t_err, n_ns, haddr, hsize, hwrite, bad);
        check_beat(tag, ecyc, !legal || er, legal, ea, size, we, ref_dato,
                   term_cyc, t_ack, t_err, n_ns, haddr, hsize, hwrite, bad);
        release_bus();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int term_cyc; logic t_ack; logic t_err; int n_ns;
        logic [31:0] haddr; logic [2:0] hsize; logic hwrite; int bad;
        logic [3:0] legal_sel[7];
        int cnt_ns; int cnt_term;

        legal_sel = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};

        //           adr            sel   we    dat            aw ws er    rdata          cyc err   legal haddr          hsize dato
        vecs[0] = '{32'h2000_0010, 4'hF, 1'b1, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'h0000_0000, 3, 1'b0, 1'b1, 32'h2000_0010, 3'd2, 32'h0000_0000};
        vecs[1] = '{32'h0000_0100, 4'h4, 1'b0, 32'h0000_0000, 0, 2, 1'b0, 32'h00AB_0000, 5, 1'b0, 1'b1, 32'h0000_0102, 3'd0, 32'h00AB_0000};
        vecs[2] = '{32'h0000_0200, 4'h6, 1'b1, 32'h1111_1111, 0, 0, 1'b0, 32'h0000_0000, 1, 1'b1, 1'b0, 32'h0000_0000, 3'd0, 32'h00AB_0000};
        vecs[3] = '{32'h0000_0040, 4'hF, 1'b1, 32'h55AA_55AA, 0, 0, 1'b1, 32'h0000_0000, 4, 1'b1, 1'b1, 32'h0000_0040, 3'd2, 32'h00AB_0000};
        vecs[4] = '{32'h0000_0033, 4'hC, 1'b0, 32'h0000_0000, 1, 1, 1'b0, 32'h1234_0000, 5, 1'b0, 1'b1, 32'h0000_0032, 3'd1, 32'h1234_0000};
        vecs[5] = '{32'h0000_0080, 4'h0, 1'b0, 32'h0000_0000, 0, 0, 1'b0, 32'h0000_0000, 1, 1'b1, 1'b0, 32'h0000_0000, 3'd0, 32'h1234_0000};
        vecs[6] = '{32'h0000_1003, 4'h8, 1'b1, 32'hA500_0000, 2, 0, 1'b0, 32'h0000_0000, 5, 1'b0, 1'b1, 32'h0000_1003, 3'd0, 32'h1234_0000};
        vecs[7] = '{32'h0000_0010, 4'h3, 1'b0, 32'h0000_0000, 0, 1, 1'b1, 32'h0000_FFFF, 5, 1'b1, 1'b1, 32'h0000_0010, 3'd1, 32'h1234_0000};
        vecs[8] = '{32'h0000_7FFC, 4'h1, 1'b0, 32'h0000_0000, 0, 0, 1'b0, 32'h0000_00C3, 3, 1'b0, 1'b1, 32'h0000_7FFC, 3'd0, 32'h0000_00C3};

        bus.ADR_I = '0; bus.DAT_I = '0; bus.SEL_I = '0; bus.CTI_I = '0; bus.BTE_I = '0;
        bus.CYC_I = 1'b0; bus.STB_I = 1'b0; bus.WE_I = 1'b0;
        bus.HRDATA = '0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;

        // Reset values
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check("rst.htrans",    {30'd0, bus.HTRANS}, {30'd0, T_IDLE});
        check("rst.haddr",     bus.HADDR, 32'h0);
        check("rst.hwdata",    bus.HWDATA, 32'h0);
        check("rst.dat_o",     bus.DAT_O, 32'h0);
        check("rst.hwrite",    {31'd0, bus.HWRITE}, 32'h0);
        check("rst.hsize",     {29'd0, bus.HSIZE}, 32'h2);
        check("rst.ack",       {31'd0, bus.ACK_O}, 32'h0);
        check("rst.err",       {31'd0, bus.ERR_O}, 32'h0);
        check("rst.rty",       {31'd0, bus.RTY_O}, 32'h0);
        check("rst.hburst",    {29'd0, bus.HBURST}, 32'h0);
        check("rst.hprot",     {28'd0, bus.HPROT}, 32'h1);
        check("rst.hmastlock", {31'd0, bus.HMASTLOCK}, 32'h0);
        HRESETn = 1'b1;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            run_beat(vecs[i].adr, vecs[i].sel, vecs[i].we, vecs[i].dat, vecs[i].aw,
                     vecs[i].ws, vecs[i].er, vecs[i].rdata, 3'b000, 1'b0, 30,
                     term_cyc, t_ack, t_err, n_ns, haddr, hsize, hwrite, bad);
            check_beat($sformatf("vec%0d", i), vecs[i].exp_cyc, vecs[i].exp_err,
                       vecs[i].exp_legal, vecs[i].exp_haddr, vecs[i].exp_hsize,
                       vecs[i].we, vecs[i].exp_dato,
                       term_cyc, t_ack, t_err, n_ns, haddr, hsize, hwrite, bad);
            release_bus();
        end
        ref_dato = vecs[8].exp_dato;

        // 4-beat ethmac burst with STB_I held high across the ACK cycles
        for (int i = 0; i < 4; i++) begin
            run_beat(32'h3000_0000 + 32'(4 * i), 4'hF, 1'b1, 32'hB000_0000 + 32'(i),
                     0, 0, 1'b0, 32'h0, (i == 3) ? 3'b111 : 3'b010, 1'b0, 30,
                     term_cyc, t_ack, t_err, n_ns, haddr, hsize, hwrite, bad);
            check_beat($sformatf("burst%0d", i), 3, 1'b0, 1'b1, 32'h3000_0000 + 32'(4 * i),
                       3'd2, 1'b1, ref_dato,
                       term_cyc, t_ack, t_err, n_ns, haddr, hsize, hwrite, bad);
        end
        release_bus();
        cnt_ns = 0; cnt_term = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge HCLK);
            if (bus.HTRANS == T_NONSEQ) cnt_ns++;
            if (bus.ACK_O || bus.ERR_O) cnt_term++;
        end
        check("burst.extra_nonseq", cnt_ns, 0);
        check("burst.extra_term", cnt_term, 0);

        // CYC_I dropped at the start of a 3-wait data phase
        run_beat(32'h0000_0500, 4'hF, 1'b1, 32'hCAFE_F00D, 0, 3, 1'b0, 32'h0,
                 3'b000, 1'b1, 10,
                 term_cyc, t_ack, t_err, n_ns, haddr, hsize, hwrite, bad);
        check("abort.term_cyc", term_cyc, -1);
        check("abort.n_nonseq", n_ns, 1);
        check("abort.haddr", haddr, 32'h0000_0500);
        check("abort.data_phase", bad, 0);
        release_bus();

        // Random beats against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [3:0] sel;
            if ($urandom_range(0, 3) == 0) sel = 4'($urandom_range(0, 15));
            else sel = legal_sel[$urandom_range(0, 6)];
            model_beat($sformatf("rnd%0d", i), $urandom, sel, 1'($urandom_range(0, 1)),
                       $urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                       $urandom_range(0, 7) == 0, $urandom);
        end

        // Reset asserted during the address phase
        @(posedge HCLK); #1;
        bus.ADR_I = 32'h0000_0600; bus.SEL_I = 4'hF; bus.WE_I = 1'b1;
        bus.DAT_I = 32'h1357_9BDF; bus.CYC_I = 1'b1; bus.STB_I = 1'b1; bus.HREADY = 1'b1;
        @(posedge HCLK); #1;
        bus.HREADY = 1'b0;
        @(negedge HCLK);
        check("rstmid.pre_htrans", {30'd0, bus.HTRANS}, {30'd0, T_NONSEQ});
        check("rstmid.pre_haddr", bus.HADDR, 32'h0000_0600);
        #2 HRESETn = 1'b0;
        #1;
        check("rstmid.htrans", {30'd0, bus.HTRANS}, {30'd0, T_IDLE});
        check("rstmid.haddr",  bus.HADDR, 32'h0);
        check("rstmid.hwdata", bus.HWDATA, 32'h0);
        check("rstmid.dat_o",  bus.DAT_O, 32'h0);
        check("rstmid.hwrite", {31'd0, bus.HWRITE}, 32'h0);
        check("rstmid.hsize",  {29'd0, bus.HSIZE}, 32'h2);
        check("rstmid.ack",    {31'd0, bus.ACK_O}, 32'h0);
        check("rstmid.err",    {31'd0, bus.ERR_O}, 32'h0);
        bus.CYC_I = 1'b0; bus.STB_I = 1'b0; bus.HREADY = 1'b1;
        @(negedge HCLK);
        HRESETn = 1'b1;
        ref_dato = 32'h0;
        cnt_ns = 0; cnt_term = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge HCLK);
            if (bus.HTRANS == T_NONSEQ) cnt_ns++;
            if (bus.ACK_O || bus.ERR_O) cnt_term++;
        end
        check("rstmid.after_nonseq", cnt_ns, 0);
        check("rstmid.after_term", cnt_term, 0);

        model_beat("post_rst", 32'h0000_0700, 4'hF, 1'b0, 32'h0, 0, 1, 1'b0, 32'h0BAD_C0DE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/wb_ahb_master_bridge.md
# wb_ahb_master_bridge

Converts the Wishbone B3 master port of the Ethernet MAC's RX/TX buffer DMA into an AHB-Lite master on the system bus. It sits directly downstream of the MAC's `m_wb_*` interface and lets the MAC read TX frames from, and write RX frames to, system memory. Each Wishbone beat becomes exactly one non-pipelined AHB SINGLE transfer. Byte-lane selects map to HSIZE/HADDR, and AHB errors are returned as Wishbone errors.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, width of ADR_I/HADDR
- `DATA_WIDTH`, 32, data width; only 32 is supported

Ports:
- `HCLK`  in  1  single bridge clock; Wishbone side is synchronous to it
- `HRESETn`  in  1  reset, asynchronous, active-low
- `ADR_I`  in  ADDR_WIDTH  Wishbone byte address; bits [1:0] ignored
- `DAT_I`  in  32  Wishbone write data
- `SEL_I`  in  4  byte-lane select
- `CTI_I`  in  3  cycle type; accepted, not used
- `BTE_I`  in  2  burst type; accepted, not used
- `CYC_I`, `STB_I`, `WE_I`  in  1 each  Wishbone cycle, strobe, write enable
- `DAT_O`  out  32  read data, registered
- `ACK_O`, `ERR_O`  out  1 each  termination, registered, one-cycle pulses
- `RTY_O`  out  1  tied 0
- `HADDR`  out  ADDR_WIDTH; `HTRANS`  out  2; `HWRITE`  out  1; `HSIZE`  out  3; `HBURST`  out  3 (always SINGLE); `HPROT`  out  4 (always 4'b0001); `HMASTLOCK`  out  1 (always 0); `HWDATA`  out  32
- `HRDATA`  in  32; `HREADY`  in  1; `HRESP`  in  1

## Operation
- FSM states: IDLE, ADDR, DATA, TERM.
- **IDLE.** On CYC_I&STB_I, decode SEL_I:
  - 1111: word, HADDR[1:0]=00.
  - 0011 / 1100: half, HADDR[1:0]=00 / 10.
  - 0001 / 0010 / 0100 / 1000: byte, HADDR[1:0]=00 / 01 / 10 / 11.
  - Legal SEL: latch address, size, WE and DAT_I, then go to ADDR.
  - Any other SEL (including 0000): go to TERM with error flag set; no AHB transfer.
- **ADDR.** Drive HTRANS=NONSEQ with the latched HADDR, HWRITE and HSIZE. When HREADY=1, go to DATA. Otherwise hold all address-phase signals.
- **DATA.** Drive HTRANS=IDLE and HWDATA=latched data, held for the whole data phase. Wait for HREADY=1, then:
  - HRESP=OKAY: capture HRDATA into DAT_O (reads only) and go to TERM.
  - HRESP=ERROR: go to TERM with error flag set. The two-cycle ERROR response is satisfied because HTRANS is already IDLE.
- **TERM.** Pulse ACK_O, or ERR_O if the error flag is set, for exactly one cycle, then return to IDLE.
  - TERM is never followed by a new transfer in the same cycle. This prevents re-issuing a beat whose STB_I is still high during the ACK cycle.
- **Abort.** CYC_I low in ADDR or DATA does not cancel the AHB transfer; it completes normally. At TERM, ACK_O/ERR_O are suppressed if CYC_I=0.
- DAT_O holds its last value on writes and errors.
- **Reset values:** FSM IDLE; HTRANS=IDLE; HADDR, HWDATA and DAT_O = 0; HWRITE=0; HSIZE=3'b010; ACK_O=0; ERR_O=0.
- **Reset mid-transfer:** all outputs return to reset values immediately; no termination is generated.

## Timing
- A beat accepted at cycle 0 produces:
  - address phase in cycle 1;
  - data phase from cycle 2;
  - ACK_O one cycle after the data phase ends with HREADY.
- Minimum latency from STB_I to ACK_O is 3 cycles (zero-wait slave); throughput is at most one beat per 4 cycles.
- Each AHB wait state (HREADY=0) adds one cycle. Wait states during the address phase (another master's data phase) also stretch latency.
- HWDATA is stable from the first data-phase cycle until HREADY=1.
- Illegal SEL_I: ERR_O at cycle 1.

## Structure
- Shared package `ahb_pkg`:
  - HTRANS codes (IDLE/NONSEQ);
  - HSIZE codes (BYTE/HALF/WORD);
  - HBURST_SINGLE;
  - HPROT_DATA;
  - FSM state encoding.
- One sub-module, `wb_sel_decode`, purely combinational: SEL_I to {legal, HSIZE, HADDR[1:0]}.
- The FSM and datapath registers live in the top module.

## Test plan
- Word write: ADR_I=0x2000_0010, SEL_I=1111, DAT_I=0xDEADBEEF, zero-wait slave. Expect HADDR=0x2000_0010, HSIZE=010, HWRITE=1 in cycle 1; HWDATA=0xDEADBEEF in cycle 2; ACK_O pulse in cycle 3.
- Byte read: SEL_I=0100 at ADR_I=0x100, slave returns HRDATA=0x00AB0000 after 2 wait states. Expect HADDR=0x102, HSIZE=000, DAT_O=0x00AB0000, and ACK_O at cycle 5.
- Illegal SEL_I=0110. Expect HTRANS to stay IDLE, ERR_O pulse at cycle 1, ACK_O=0.
- AHB ERROR on a write. Expect HTRANS=IDLE in both error cycles, ERR_O one pulse, no ACK_O.
- 4-beat ethmac burst (CTI 010, 010, 010, 111) with STB_I held high. Expect exactly 4 NONSEQ transfers at HADDR +0, +4, +8, +C, 4 ACK_O pulses, and no duplicate transfer.
- Abort and reset:
  - CYC_I dropped during a data phase with HREADY low for 3 cycles: the transfer completes and no ACK_O is generated.
  - HRESETn asserted in ADDR: HTRANS=IDLE asynchronously and all outputs take their reset values.
